// File: rtl/pid_controller_core_if.sv
// ---------------------------------------------------------------------------
// pid_controller_core_if
// Sample, control and coefficient bundle between the upstream
// filter/host side and the PID computation core.
//   data_in/dv_in           : signed input sample and its one-cycle strobe
//   lock_en_in              : loop active (1) or held cleared (0)
//   setpoint_in, *_coef_in  : signed host parameters
//   update_en_in/update_in  : gated parameter-load trigger
//   data_out/dv_out         : saturated signed result and its strobe
// master = sample/host side, slave = PID core.
// ---------------------------------------------------------------------------
interface pid_controller_core_if #(
   parameter int W_IN   = 18,
   parameter int W_COEF = 16,
   parameter int W_OUT  = 18
);
   logic signed [W_IN-1:0]   data_in;
   logic                     dv_in;
   logic                     lock_en_in;
   logic signed [W_COEF-1:0] setpoint_in;
   logic signed [W_COEF-1:0] p_coef_in;
   logic signed [W_COEF-1:0] i_coef_in;
   logic signed [W_COEF-1:0] d_coef_in;
   logic                     update_en_in;
   logic                     update_in;
   logic signed [W_OUT-1:0]  data_out;
   logic                     dv_out;

   modport master (
      output data_in, dv_in, lock_en_in, setpoint_in, p_coef_in, i_coef_in,
             d_coef_in, update_en_in, update_in,
      input  data_out, dv_out
   );

   modport slave (
      input  data_in, dv_in, lock_en_in, setpoint_in, p_coef_in, i_coef_in,
             d_coef_in, update_en_in, update_in,
      output data_out, dv_out
   );
endinterface

// File: rtl/pid_controller_core.sv
// ---------------------------------------------------------------------------
// pid_controller_core
// Fully pipelined fixed-point PID: u = P*e + I*sum(e) + D*(e - e_prev),
// e = setpoint - sample, result saturated to W_OUT bits. One sample per
// cycle, result strobed 4 edges after the input strobe.
// Ports:
//   clk_in   : system clock, rising edge
//   n_rst_in : synchronous active-low reset, clears all state
//   pid_bus  : slave side of pid_controller_core_if (samples, control,
//              coefficients, result)
// ---------------------------------------------------------------------------
module pid_controller_core #(
   parameter int W_IN   = 18,
   parameter int W_COEF = 16,
   parameter int W_OUT  = 18,
   parameter int W_INTG = 36
) (
   input logic                  clk_in,
   input logic                  n_rst_in,
   pid_controller_core_if.slave pid_bus
);

   localparam int E_W   = W_IN + 1;
   localparam int D_W   = W_IN + 2;
   localparam int PP_W  = W_COEF + E_W;
   localparam int PI_W  = W_COEF + W_INTG;
   localparam int PD_W  = W_COEF + D_W;
   localparam int SUM_W = W_COEF + W_INTG + 2;

   // Symmetric clamp so the accumulator never wraps and never reaches -2^(W-1).
   function automatic logic signed [W_INTG-1:0] sat_intg(input logic signed [W_INTG:0] x);
      logic signed [W_INTG:0] hi;
      logic signed [W_INTG:0] lo;
      hi = '0;
      hi[W_INTG-2:0] = '1;
      lo = -hi;
      if (x > hi)      sat_intg = hi[W_INTG-1:0];
      else if (x < lo) sat_intg = lo[W_INTG-1:0];
      else             sat_intg = x[W_INTG-1:0];
   endfunction

   function automatic logic signed [W_OUT-1:0] sat_out(input logic signed [SUM_W-1:0] x);
      logic signed [SUM_W-1:0] hi;
      logic signed [SUM_W-1:0] lo;
      hi = '0;
      hi[W_OUT-2:0] = '1;
      lo = ~hi;
      if (x > hi)      sat_out = hi[W_OUT-1:0];
      else if (x < lo) sat_out = lo[W_OUT-1:0];
      else             sat_out = x[W_OUT-1:0];
   endfunction

   logic signed [W_COEF-1:0] sp_r, p_r, i_r, d_r;

   logic                     vld_p1, lock_p1;
   logic signed [E_W-1:0]    e_p1;
   logic signed [W_COEF-1:0] p_p1, i_p1, d_p1;

   logic signed [W_INTG-1:0] intg;
   logic signed [E_W-1:0]    e_prev;

   logic                     vld_p2, zero_p2;
   logic signed [E_W-1:0]    e_p2;
   logic signed [D_W-1:0]    delta_p2;
   logic signed [W_COEF-1:0] p_p2, i_p2, d_p2;

   logic                     vld_p3, zero_p3;
   logic signed [PP_W-1:0]   prod_p_p3;
   logic signed [PI_W-1:0]   prod_i_p3;
   logic signed [PD_W-1:0]   prod_d_p3;

   logic                     vld_p4, zero_p4;
   logic signed [SUM_W-1:0]  sum_p4;

   logic signed [E_W-1:0]    e_next;
   logic signed [W_INTG:0]   intg_sum;
   logic signed [D_W-1:0]    delta_next;

   always_comb begin
      e_next     = E_W'(sp_r) - E_W'(pid_bus.data_in);
      intg_sum   = (W_INTG+1)'(intg) + (W_INTG+1)'(e_p1);
      delta_next = D_W'(e_p1) - D_W'(e_prev);
   end

   always_ff @(posedge clk_in) begin
      if (!n_rst_in) begin
         sp_r             <= '0;
         p_r              <= '0;
         i_r              <= '0;
         d_r              <= '0;
         vld_p1           <= 1'b0;
         lock_p1          <= 1'b0;
         e_p1             <= '0;
         p_p1             <= '0;
         i_p1             <= '0;
         d_p1             <= '0;
         intg             <= '0;
         e_prev           <= '0;
         vld_p2           <= 1'b0;
         zero_p2          <= 1'b0;
         e_p2             <= '0;
         delta_p2         <= '0;
         p_p2             <= '0;
         i_p2             <= '0;
         d_p2             <= '0;
         vld_p3           <= 1'b0;
         zero_p3          <= 1'b0;
         prod_p_p3        <= '0;
         prod_i_p3        <= '0;
         prod_d_p3        <= '0;
         vld_p4           <= 1'b0;
         zero_p4          <= 1'b0;
         sum_p4           <= '0;
         pid_bus.data_out <= '0;
         pid_bus.dv_out   <= 1'b0;
      end else begin
         if (pid_bus.update_in && pid_bus.update_en_in) begin
            sp_r <= pid_bus.setpoint_in;
            p_r  <= pid_bus.p_coef_in;
            i_r  <= pid_bus.i_coef_in;
            d_r  <= pid_bus.d_coef_in;
         end

         // Stage 1: error; coefficients travel with the sample so a load on
         // the same edge only affects later samples.
         vld_p1 <= pid_bus.dv_in;
         if (pid_bus.dv_in) begin
            lock_p1 <= pid_bus.lock_en_in;
            e_p1    <= e_next;
            p_p1    <= p_r;
            i_p1    <= i_r;
            d_p1    <= d_r;
         end

         // Stage 2: integral and derivative state
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            e_p2 <= e_p1;
            p_p2 <= p_p1;
            i_p2 <= i_p1;
            d_p2 <= d_p1;
            if (lock_p1) begin
               intg     <= sat_intg(intg_sum);
               delta_p2 <= delta_next;
               e_prev   <= e_p1;
               zero_p2  <= 1'b0;
            end else begin
               intg     <= '0;
               delta_p2 <= '0;
               e_prev   <= '0;
               zero_p2  <= 1'b1;
            end
         end

         // Stage 3: products; intg still holds this sample's updated sum here
         vld_p3 <= vld_p2;
         if (vld_p2) begin
            zero_p3   <= zero_p2;
            prod_p_p3 <= PP_W'(p_p2) * PP_W'(e_p2);
            prod_i_p3 <= PI_W'(i_p2) * PI_W'(intg);
            prod_d_p3 <= PD_W'(d_p2) * PD_W'(delta_p2);
         end

         // Stage 4: full-width sum
         vld_p4 <= vld_p3;
         if (vld_p3) begin
            zero_p4 <= zero_p3;
            sum_p4  <= SUM_W'(prod_p_p3) + SUM_W'(prod_i_p3) + SUM_W'(prod_d_p3);
         end

         // Output: saturate; data_out holds between results
         pid_bus.dv_out <= vld_p4;
         if (vld_p4) begin
            pid_bus.data_out <= zero_p4 ? '0 : sat_out(sum_p4);
         end
      end
   end

endmodule

// File: tb/tb_pid_controller_core.sv
module tb_pid_controller_core;
   localparam int W_IN   = 18;
   localparam int W_COEF = 16;
   localparam int W_OUT  = 18;
   localparam int W_INTG = 36;

   localparam longint INTG_LIM = (64'sd1 <<< (W_INTG - 1)) - 1;
   localparam longint OUT_MAX  = (64'sd1 <<< (W_OUT - 1)) - 1;
   localparam longint OUT_MIN  = -OUT_MAX - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pid_controller_core_if #(.W_IN(W_IN), .W_COEF(W_COEF), .W_OUT(W_OUT)) pid_bus ();

   pid_controller_core #(
      .W_IN(W_IN), .W_COEF(W_COEF), .W_OUT(W_OUT), .W_INTG(W_INTG)
   ) dut (
      .clk_in  (clk),
      .n_rst_in(rst_n),
      .pid_bus (pid_bus)
   );

   typedef struct {
      longint val;
      int     cyc;
   } exp_t;

   typedef struct {
      int     data;
      bit     lock;
      longint exp;
   } vec_t;

   exp_t   q[$];
   int     tests = 0;
   int     fails = 0;
   int     cyc = 0;
   longint last_out = 0;
   bit     mon_en = 1'b0;

   // behavioural model state: parameters as loaded, integral, previous error
   longint m_sp = 0, m_p = 0, m_i = 0, m_d = 0, m_sig = 0, m_eprev = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Results are checked in order as dv_out appears; between results data_out must hold.
   exp_t mx;
   always @(negedge clk) begin
      if (mon_en) begin
         if (pid_bus.dv_out) begin
            if (q.size() == 0) begin
               check("unexpected_dv_out", longint'(pid_bus.dv_out), 0);
            end else begin
               mx = q.pop_front();
               check("data_out", longint'(pid_bus.data_out), mx.val);
               check("latency", longint'(cyc), longint'(mx.cyc + 4));
               last_out = mx.val;
            end
         end else begin
            check("hold", longint'(pid_bus.data_out), last_out);
         end
      end
   end

   function automatic longint clamp(input longint x, input longint lo, input longint hi);
      return (x > hi) ? hi : ((x < lo) ? lo : x);
   endfunction

   function automatic longint model_step(input longint data, input bit lock);
      longint e, delta, u;
      if (!lock) begin
         m_sig   = 0;
         m_eprev = 0;
         return 0;
      end
      e       = m_sp - data;
      m_sig   = clamp(m_sig + e, -INTG_LIM, INTG_LIM);
      delta   = e - m_eprev;
      m_eprev = e;
      u       = m_p * e + m_i * m_sig + m_d * delta;
      return clamp(u, OUT_MIN, OUT_MAX);
   endfunction

   task automatic model_load();
      m_sp = pid_bus.setpoint_in;
      m_p  = pid_bus.p_coef_in;
      m_i  = pid_bus.i_coef_in;
      m_d  = pid_bus.d_coef_in;
   endtask

   task automatic model_clear();
      q.delete();
      m_sp = 0; m_p = 0; m_i = 0; m_d = 0; m_sig = 0; m_eprev = 0;
      last_out = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_coefs(input int sp, input int p, input int i, input int d);
      pid_bus.setpoint_in = 16'(sp);
      pid_bus.p_coef_in   = 16'(p);
      pid_bus.i_coef_in   = 16'(i);
      pid_bus.d_coef_in   = 16'(d);
   endtask

   task automatic load(input bit en);
      pid_bus.update_en_in = en;
      pid_bus.update_in    = 1'b1;
      tick();
      if (en && rst_n) model_load();
      pid_bus.update_in = 1'b0;
   endtask

   // One sample; expectation is either the given constant or the model's value.
   task automatic send(input int data, input bit lock, input bit upd,
                       input bit has_exp, input longint exp);
      longint u;
      exp_t   x;
      pid_bus.data_in    = 18'(data);
      pid_bus.dv_in      = 1'b1;
      pid_bus.lock_en_in = lock;
      pid_bus.update_in  = upd;
      u = rst_n ? model_step(longint'(data), lock) : 0;
      if (upd && pid_bus.update_en_in && rst_n) model_load();
      tick();
      if (rst_n) begin
         x.val = has_exp ? exp : u;
         x.cyc = cyc;
         q.push_back(x);
      end
      pid_bus.dv_in     = 1'b0;
      pid_bus.update_in = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   vec_t basic[3];

   initial begin
      bit upd;
      basic[0] = '{2222, 1'b1, -33330};
      basic[1] = '{2222, 1'b1, -35552};
      basic[2] = '{2222, 1'b1, -42218};

      pid_bus.data_in = '0;  pid_bus.dv_in = 1'b0;  pid_bus.lock_en_in = 1'b0;
      pid_bus.update_en_in = 1'b0;  pid_bus.update_in = 1'b0;
      set_coefs(0, 0, 0, 0);
      rst_n = 1'b0;
      idle(2);
      mon_en = 1'b1;

      // Reset held: strobes and a load attempt are ignored
      set_coefs(0, 10, 3, 2);
      pid_bus.update_en_in = 1'b1;
      pid_bus.update_in    = 1'b1;
      for (int k = 0; k < 3; k++) begin
         pid_bus.data_in    = 18'(1000 + k);
         pid_bus.dv_in      = 1'b1;
         pid_bus.lock_en_in = 1'b1;
         tick();
         pid_bus.dv_in = 1'b0;
         tick();
         check("rst_dv_out", longint'(pid_bus.dv_out), 0);
         check("rst_data_out", longint'(pid_bus.data_out), 0);
      end
      pid_bus.update_in = 1'b0;
      rst_n = 1'b1;

      // Coefficients still zero after reset
      send(2222, 1'b1, 1'b0, 1'b1, 0);
      send(2222, 1'b0, 1'b0, 1'b1, 0);

      // Basic PID sequence
      set_coefs(0, 10, 3, 2);
      load(1'b1);
      for (int k = 0; k < 3; k++) send(basic[k].data, basic[k].lock, 1'b0, 1'b1, basic[k].exp);
      idle(6);

      // Update gating
      set_coefs(0, 100, 3, 2);
      load(1'b0);
      send(2222, 1'b1, 1'b0, 1'b1, -48884);
      load(1'b1);
      send(2222, 1'b1, 1'b0, 1'b1, -131072);
      set_coefs(0, 5, 3, 2);
      send(2222, 1'b1, 1'b1, 1'b1, -131072);
      send(2222, 1'b1, 1'b0, 1'b1, -57772);
      idle(6);

      // Saturation
      send(0, 1'b0, 1'b0, 1'b1, 0);
      set_coefs(0, 32767, 0, 0);
      load(1'b1);
      send(-131072, 1'b1, 1'b0, 1'b1, 131071);
      send(131071, 1'b1, 1'b0, 1'b1, -131072);
      set_coefs(0, 32767, 3, 0);
      load(1'b1);
      repeat (20) send(-131072, 1'b1, 1'b0, 1'b1, 131071);
      idle(6);

      // Lock drop and derivative
      send(100, 1'b0, 1'b0, 1'b1, 0);
      set_coefs(0, 0, 0, 1);
      load(1'b1);
      send(2222, 1'b1, 1'b0, 1'b1, -2222);
      send(2000, 1'b1, 1'b0, 1'b1, 222);
      idle(6);

      // Back-to-back
      set_coefs(-300, 10, 3, 2);
      load(1'b1);
      for (int k = 0; k < 4; k++) send(int'($urandom_range(0, 262143)) - 131072, 1'b1, 1'b0, 1'b0, 0);
      idle(6);

      // Reset two edges after a sample: no result for it
      send(1234, 1'b1, 1'b0, 1'b0, 0);
      tick();
      rst_n = 1'b0;
      tick();
      model_clear();
      rst_n = 1'b1;
      check("mid_rst_data_out", longint'(pid_bus.data_out), 0);
      check("mid_rst_dv_out", longint'(pid_bus.dv_out), 0);
      idle(8);

      // Randomized traffic against the model
      for (int n = 0; n < 300; n++) begin
         upd = 1'b0;
         if ($urandom_range(0, 7) == 0) begin
            set_coefs(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                      int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
            pid_bus.update_en_in = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) load(pid_bus.update_en_in);
            else upd = 1'b1;
         end
         send(int'($urandom_range(0, 262143)) - 131072, ($urandom_range(0, 9) != 0), upd, 1'b0, 0);
         repeat ($urandom_range(0, 2)) tick();
      end

      for (int k = 0; k < 20 && q.size() != 0; k++) tick();
      check("drain", longint'(q.size()), 0);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
